flt_addsub_seq: RTL and testbench

//  Parametrised sequential floating-point add/subtract unit; next generation of the half-precision adder.

---
 rtl/flt_pkg.sv | 24 ++
 rtl/flt_shift_norm.sv | 26 ++
 rtl/flt_addsub_seq.sv | 206 ++++++++++++++++++++
 tb/tb_flt_addsub_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flt_pkg.sv
// Shared types and default geometry for the sequential floating-point add/subtract unit.
package flt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_PACK,
    ST_DONE
  } state_t;

  localparam int unsigned FLT_EXP_W   = 5;
  localparam int unsigned FLT_MAN_W   = 10;
  localparam int unsigned FLT_BIAS    = 15;
  localparam int unsigned FLT_EXP_MAX = (1 << FLT_EXP_W) - 1;

  // Working mantissa frame: carry, hidden, MAN_W fraction bits, guard, round, sticky.
  function automatic int unsigned frame_w(input int unsigned man_w);
    return man_w + 5;
  endfunction

endpackage

// File: rtl/flt_shift_norm.sv
// One-bit-per-cycle mantissa shifter; right shifts fold the lost bit into the sticky LSB.
module flt_shift_norm #(
  parameter int unsigned W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shr,
  input  logic         shl,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shr) begin
      q <= {1'b0, q[W-1:2], q[1] | q[0]};
    end else if (shl) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/flt_addsub_seq.sv
// Sequential floating-point add/subtract coprocessor with start/done handshake.
// Define FLT_RND_EN for round-to-nearest-even; otherwise the result is truncated.
module flt_addsub_seq
  import flt_pkg::*;
#(
  parameter int unsigned EXP_W = FLT_EXP_W,
  parameter int unsigned MAN_W = FLT_MAN_W,
  parameter int unsigned BIAS  = FLT_BIAS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done,
  output logic                   busy,
  output logic                   ovf,
  output logic                   unf
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned FW  = frame_w(MAN_W);
  localparam int unsigned HID = MAN_W + 3;
  localparam logic [EXP_W-1:0]        SKIP_E   = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W-1:0]        DIFF_ONE = EXP_W'(1);
  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_TOP  = (EXP_W+2)'(2 * BIAS + 1);

  state_t state, state_n;
  logic start_q, launch_req;
  logic [W-1:0] opa_q, opb_q;
  logic sub_q;
  logic [FW-1:0] frame_l;
  logic sign_l, sign_s, inf_q;
  logic signed [EXP_W+1:0] exp_q;
  logic [EXP_W-1:0] diff_q;

  logic sh_load, sh_shr, sh_shl;
  logic [FW-1:0] sh_d, sh_q;

  logic [EXP_W-1:0] ea, eb, e_l, e_s, dexp, d_eff;
  logic [FW-1:0] fa, fb, f_l, f_s, f_s_al, sum;
  logic sgn_b, s_l, s_s, swap;

  logic rup, rc;
  logic [MAN_W-1:0] frac_r;
  logic signed [EXP_W+1:0] exp_r;
  logic [W-1:0] pk_res;
  logic pk_ovf, pk_unf;

  assign launch_req = start_q & ~start;
  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE) && (state != ST_DONE);

  flt_shift_norm #(.W(FW)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shr   (sh_shr),
    .shl   (sh_shl),
    .d     (sh_d),
    .q     (sh_q)
  );

  // Unpack, order by magnitude and pre-resolve the alignment distance.
  always_comb begin
    ea    = opa_q[W-2 -: EXP_W];
    eb    = opb_q[W-2 -: EXP_W];
    sgn_b = opb_q[W-1] ^ sub_q;
    fa    = (|ea) ? {2'b01, opa_q[MAN_W-1:0], 3'b000} : '0;
    fb    = (|eb) ? {2'b01, opb_q[MAN_W-1:0], 3'b000} : '0;
    swap  = {eb, fb} > {ea, fa};
    e_l   = swap ? eb : ea;
    e_s   = swap ? ea : eb;
    f_l   = swap ? fb : fa;
    f_s   = swap ? fa : fb;
    s_l   = swap ? sgn_b : opa_q[W-1];
    s_s   = swap ? opa_q[W-1] : sgn_b;
    dexp  = e_l - e_s;
    f_s_al = f_s;
    d_eff  = dexp;
    if (e_s == '0) begin
      d_eff = '0;
    end else if (dexp > SKIP_E) begin
      // Too far apart to reach the guard bits: collapse straight to sticky.
      f_s_al = {{(FW-1){1'b0}}, |f_s};
      d_eff  = '0;
    end
    sum = (sign_l == sign_s) ? frame_l + sh_q : frame_l - sh_q;
  end

  // Round, then classify the final exponent.
  always_comb begin
`ifdef FLT_RND_EN
    rup = sh_q[2] & (sh_q[1] | sh_q[0] | sh_q[3]);
`else
    rup = 1'b0;
`endif
    {rc, frac_r} = {1'b0, sh_q[HID-1:3]} + {{MAN_W{1'b0}}, rup};
    exp_r  = exp_q + $signed({{(EXP_W+1){1'b0}}, rc});
    pk_res = {sign_l, exp_r[EXP_W-1:0], frac_r};
    pk_ovf = 1'b0;
    pk_unf = 1'b0;
    if (inf_q || exp_r >= EXP_TOP) begin
      pk_res = {sign_l, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pk_ovf = 1'b1;
    end else if (sh_q == '0) begin
      pk_res = '0;
    end else if (exp_r < EXP_ONE) begin
      pk_res = {sign_l, {(W-1){1'b0}}};
      pk_unf = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    sh_load = 1'b0;
    sh_shr  = 1'b0;
    sh_shl  = 1'b0;
    sh_d    = f_s_al;
    case (state)
      ST_IDLE, ST_DONE: if (launch_req) state_n = ST_LOAD;
      ST_LOAD: begin
        sh_load = 1'b1;
        state_n = (d_eff != '0) ? ST_ALIGN : ST_ADD;
      end
      ST_ALIGN: begin
        sh_shr = 1'b1;
        if (diff_q == DIFF_ONE) state_n = ST_ADD;
      end
      ST_ADD: begin
        sh_load = 1'b1;
        sh_d    = sum;
        if (sum == '0)                   state_n = ST_PACK;
        else if (sum[FW-1] || !sum[HID]) state_n = ST_NORM;
        else                             state_n = ST_PACK;
      end
      ST_NORM: begin
        if (sh_q[FW-1]) begin
          sh_shr  = 1'b1;
          state_n = ST_PACK;
        end else begin
          sh_shl = 1'b1;
          if (sh_q[HID-1]) state_n = ST_PACK;
        end
      end
      ST_PACK: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sub_q   <= 1'b0;
      frame_l <= '0;
      sign_l  <= 1'b0;
      sign_s  <= 1'b0;
      inf_q   <= 1'b0;
      exp_q   <= '0;
      diff_q  <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch_req) begin
            opa_q <= op_a;
            opb_q <= op_b;
            sub_q <= sub;
            ovf   <= 1'b0;
            unf   <= 1'b0;
          end
        end
        ST_LOAD: begin
          frame_l <= f_l;
          sign_l  <= s_l;
          sign_s  <= s_s;
          exp_q   <= $signed({2'b00, e_l});
          diff_q  <= d_eff;
          inf_q   <= (&ea) | (&eb);
        end
        ST_ALIGN: diff_q <= diff_q - DIFF_ONE;
        ST_NORM:  exp_q  <= sh_q[FW-1] ? exp_q + EXP_ONE : exp_q - EXP_ONE;
        ST_PACK: begin
          result <= pk_res;
          ovf    <= pk_ovf;
          unf    <= pk_unf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt_addsub_seq.sv
// Self-checking bench for flt_addsub_seq: directed vectors plus random operands scored
// against a real-valued model. Honours FLT_RND_EN the same way as the design.
module tb_flt_addsub_seq;

`ifdef FLT_RND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic        ov;
    logic        un;
  } vec_t;

  localparam vec_t VECS [9] = '{
    '{16'h1A04, 16'h1A04, 1'b0, 16'h1E04, 1'b0, 1'b0},
    '{16'h4A10, 16'h4204, 1'b0, 16'h4B91, 1'b0, 1'b0},
    '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0},
    '{16'h3C00, 16'hBA00, 1'b0, 16'h3400, 1'b0, 1'b0},
    '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0},
    '{16'h3C03, 16'h3C00, 1'b0, RND ? 16'h4002 : 16'h4001, 1'b0, 1'b0},
    '{16'h0000, 16'hC500, 1'b1, 16'h4500, 1'b0, 1'b0},
    '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b1, 1'b0},
    '{16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, 1'b1}
  };

  logic        clk = 1'b0;
  logic        reset, start, sub;
  logic [15:0] op_a, op_b, result;
  logic        done, busy, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flt_addsub_seq #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf),
    .unf    (unf)
  );

  task automatic check(input string tag, input int got, input int req, input int tol);
    int d;
    n_tests++;
    d = got - req;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (tol %0d)", tag, got, req, tol);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    v = real'(1024 + int'(h[9:0])) / 1024.0;
    while (e > 15) begin v = v * 2.0; e--; end
    while (e < 15) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  // Exact real sum, quantised to half precision; also predicts shift-cycle latency.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] res, output logic ov, output logic un,
                       output int lat);
    logic [15:0] bx;
    logic [14:0] ka, kb;
    logic        sg, neg;
    int          ea, eb, el, es, d, na, nn, ex, e, mi;
    real         r, x, f, fr;
    bx = {b[15] ^ s, b[14:0]};
    ea = int'(a[14:10]);
    eb = int'(bx[14:10]);
    ka = {a[14:10],  (ea != 0) ? a[9:0]  : 10'h0};
    kb = {bx[14:10], (eb != 0) ? bx[9:0] : 10'h0};
    if (kb > ka) begin el = eb; es = ea; sg = bx[15]; end
    else         begin el = ea; es = eb; sg = a[15];  end
    d  = el - es;
    na = (es == 0 || d > 13) ? 0 : d;
    r  = h2r(a) + h2r(bx);
    res = 16'h0000; ov = 1'b0; un = 1'b0; nn = 0;
    if (r != 0.0) begin
      neg = (r < 0.0);
      x   = neg ? -r : r;
      ex  = 0;
      while (x >= 2.0) begin x = x / 2.0; ex++; end
      while (x < 1.0)  begin x = x * 2.0; ex--; end
      nn = (ex > el - 15) ? 1 : (el - 15) - ex;
      f  = x * 1024.0;
      mi = $rtoi(f);
      fr = f - real'(mi);
      if (RND && (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1))) mi++;
      e = ex + 15;
      if (mi == 2048) begin mi = 1024; e++; end
      if (e >= 31)     begin res = {neg, 5'h1f, 10'h000}; ov = 1'b1; end
      else if (e <= 0) begin res = {neg, 15'h0000};       un = 1'b1; end
      else             res = {neg, 5'(e), 10'(mi)};
    end
    if (ea == 31 || eb == 31) begin
      res = {sg, 5'h1f, 10'h000}; ov = 1'b1; un = 1'b0;
    end
    lat = 4 + na + nn;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int tol, input string nm);
    logic [15:0] e_res;
    logic        e_ov, e_un, busy1;
    int          e_lat, cyc, viol;
    model(a, b, s, e_res, e_ov, e_un, e_lat);
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin
      op_a = a; op_b = b; sub = s; start = 1'b0;
    end
    cyc = 0; viol = 0; busy1 = 1'b0;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        busy1 = busy;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        sub   = ~s;
      end
      if (busy && done) viol++;
      if (done) break;
    end
    check({nm, "_done"}, int'(done), 1, 0);
    check({nm, "_lat"}, cyc, e_lat, 0);
    check({nm, "_busy"}, int'(busy1), 1, 0);
    check({nm, "_excl"}, viol, 0, 0);
    check({nm, "_res"}, int'(result), int'(e_res), tol);
    check({nm, "_ovf"}, int'(ovf), int'(e_ov), 0);
    check({nm, "_unf"}, int'(unf), int'(e_un), 0);
  endtask

  function automatic int clamp_exp(input int e);
    return (e < 1) ? 1 : (e > 30) ? 30 : e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int ea, eb, roll;
    reset = 1'b1; start = 1'b1; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res",  int'(result), 0, 0);
    check("rst_done", int'(done),   0, 0);
    check("rst_busy", int'(busy),   0, 0);
    check("rst_ovf",  int'(ovf),    0, 0);
    check("rst_unf",  int'(unf),    0, 0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(VECS[i].a, VECS[i].b, VECS[i].s, 0, $sformatf("dir%0d", i));
      check($sformatf("dir%0d_spec_res", i), int'(result), int'(VECS[i].r), 0);
      check($sformatf("dir%0d_spec_flags", i), int'({ovf, unf}),
            int'({VECS[i].ov, VECS[i].un}), 0);
    end

    // Abort in ALIGN, then confirm the unit recovers cleanly.
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin op_a = 16'h4A10; op_b = 16'h4204; sub = 1'b0; start = 1'b0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_done", int'(done),   0, 0);
    check("abort_busy", int'(busy),   0, 0);
    check("abort_res",  int'(result), 0, 0);
    @(negedge clk) reset = 1'b0;
    run_op(16'h4A10, 16'h4204, 1'b0, 0, "after_abort");
    check("after_abort_spec", int'(result), 16'h4B91, 0);

    for (int i = 0; i < 200; i++) begin
      roll = int'($urandom_range(0, 99));
      ea = int'($urandom_range(1, 30));
      if (roll < 8)       ea = 0;
      else if (roll < 11) ea = 31;
      roll = int'($urandom_range(0, 99));
      if (roll < 40)      eb = clamp_exp(ea + int'($urandom_range(0, 4)) - 2);
      else if (roll < 48) eb = 0;
      else if (roll < 51) eb = 31;
      else                eb = int'($urandom_range(1, 30));
      ra = {1'($urandom), 5'(ea), 10'($urandom)};
      rb = {1'($urandom), 5'(eb), 10'($urandom)};
      if ($urandom_range(0, 9) == 0) rb[14:0] = ra[14:0];
      run_op(ra, rb, 1'($urandom), 1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
